// File: rtl/mux_pipe_n.sv
// -----------------------------------------------------------------------------
// mux_pipe_n
//   N-way operand select with a registered, back-pressurable output. One of
//   N_IN WIDTH-bit inputs is picked by sel and pushed through a single output
//   register that is backed by a one-entry skid buffer. in_ready is a pure
//   register output, so there is no combinational path from out_ready back to
//   the upstream side. Out-of-range selects are flagged (sticky) and counted
//   (saturating). With BAD_MODE 0 such beats are dropped. With BAD_MODE 1 they
//   are forwarded as zero data carrying the offending sel.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   in_data   in   N_IN*WIDTH packed inputs, input i = in_data[i*WIDTH +: WIDTH]
//   sel       in   SEL_W input index, sampled with in_valid
//   in_valid  in   upstream beat present
//   in_ready  out  stage can accept a beat this cycle
//   out_data  out  WIDTH selected data
//   out_sel   out  SEL_W sel that produced out_data
//   out_valid out  out_data/out_sel valid
//   out_ready in   downstream accepts beat
//   bad_sel   out  sticky out-of-range select flag
//   bad_cnt   out  CNT_W saturating out-of-range select count
// -----------------------------------------------------------------------------
module mux_pipe_n #(
  parameter int WIDTH    = 32,
  parameter int N_IN     = 3,
  parameter int SEL_W    = 2,
  parameter int BAD_MODE = 0,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  bad_sel,
  output logic [CNT_W-1:0]      bad_cnt
);

  localparam logic [SEL_W:0] NIN_L    = (SEL_W+1)'(N_IN);
  localparam bit             PASS_BAD = (BAD_MODE != 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] mux_data_p0;
  logic             bad_p0;
  logic             accept_p0;
  logic             fwd_p0;
  logic             load_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] sel_p1;
  logic             skid_vld_p1;
  logic [WIDTH-1:0] skid_data_p1;
  logic [SEL_W-1:0] skid_sel_p1;
  logic             bad_sel_r;
  logic [CNT_W-1:0] bad_cnt_r;

  // ---- stage p0: select, classify, handshake ----
  always_comb begin
    mux_data_p0 = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel == SEL_W'(i)) mux_data_p0 = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign bad_p0    = ({1'b0, sel} >= NIN_L);
  assign in_ready  = ~skid_vld_p1 & ~reset;
  assign accept_p0 = in_valid & in_ready;
  // An accepted out-of-range beat only travels on when BAD_MODE passes it as zero data
  assign fwd_p0    = accept_p0 & (~bad_p0 | PASS_BAD);
  assign load_p0   = ~vld_p1 | out_ready;

  // ---- stage p1: output register, skid buffer, bad-select tracking ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      data_p1     <= '0;
      sel_p1      <= '0;
      skid_vld_p1 <= 1'b0;
      bad_sel_r   <= 1'b0;
      bad_cnt_r   <= '0;
    end else begin
      if (load_p0) begin
        // Skid content is older than any incoming beat, so it always drains first
        if (skid_vld_p1) begin
          vld_p1      <= 1'b1;
          data_p1     <= skid_data_p1;
          sel_p1      <= skid_sel_p1;
          skid_vld_p1 <= 1'b0;
        end else if (fwd_p0) begin
          vld_p1  <= 1'b1;
          data_p1 <= mux_data_p0;
          sel_p1  <= sel;
        end else begin
          vld_p1 <= 1'b0;
        end
      end else if (fwd_p0) begin
        skid_vld_p1 <= 1'b1;
      end
      if (accept_p0 && bad_p0) begin
        bad_sel_r <= 1'b1;
        bad_cnt_r <= sat_inc(bad_cnt_r);
      end
    end
  end

  // Skid payload needs no reset: it is only observed while skid_vld_p1 is set
  always_ff @(posedge clk) begin
    if (!load_p0 && fwd_p0) begin
      skid_data_p1 <= mux_data_p0;
      skid_sel_p1  <= sel;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;
  assign bad_sel   = bad_sel_r;
  assign bad_cnt   = bad_cnt_r;

endmodule

// File: tb/tb_mux_pipe_n.sv
// -----------------------------------------------------------------------------
// tb_mux_pipe_n
//   Bench for mux_pipe_n. Three instances share one stimulus: the default
//   configuration, a BAD_MODE 1 variant and a CNT_W 2 variant. A queue model of
//   the default instance holds accepted, not-yet-consumed beats. Its head is
//   the expected output, and two entries mean the stage is full.
// -----------------------------------------------------------------------------
module tb_mux_pipe_n;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*W-1:0]  in_data;
  logic [SW-1:0]   sel;
  logic            in_valid;
  logic            out_ready;

  logic            in_ready,  out_valid,  bad_sel;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic [7:0]      bad_cnt;

  logic            in_ready1, out_valid1, bad_sel1;
  logic [W-1:0]    out_data1;
  logic [SW-1:0]   out_sel1;
  logic [7:0]      bad_cnt1;

  logic            in_ready2, out_valid2, bad_sel2;
  logic [W-1:0]    out_data2;
  logic [SW-1:0]   out_sel2;
  logic [1:0]      bad_cnt2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mux_pipe_n #(.WIDTH(W), .N_IN(N), .SEL_W(SW), .BAD_MODE(0), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .bad_sel(bad_sel), .bad_cnt(bad_cnt));

  mux_pipe_n #(.WIDTH(W), .N_IN(N), .SEL_W(SW), .BAD_MODE(1), .CNT_W(8)) u_bad1 (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready1), .out_data(out_data1), .out_sel(out_sel1), .out_valid(out_valid1),
    .out_ready(out_ready), .bad_sel(bad_sel1), .bad_cnt(bad_cnt1));

  mux_pipe_n #(.WIDTH(W), .N_IN(N), .SEL_W(SW), .BAD_MODE(0), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready2), .out_data(out_data2), .out_sel(out_sel2), .out_valid(out_valid2),
    .out_ready(out_ready), .bad_sel(bad_sel2), .bad_cnt(bad_cnt2));

  // ---------------- reference model of u_dut ----------------
  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
  } beat_t;

  beat_t q[$];
  int    m_cnt = 0;
  bit    m_bad = 0;

  always @(posedge clk) begin
    bit    acc;
    bit    cons;
    beat_t b;
    if (reset) begin
      q.delete();
      m_cnt = 0;
      m_bad = 0;
    end else begin
      acc  = in_valid && (q.size() < 2);
      cons = (q.size() > 0) && out_ready;
      if (cons) void'(q.pop_front());
      if (acc) begin
        if (int'(sel) >= N) begin
          m_bad = 1;
          if (m_cnt < 255) m_cnt++;
        end else begin
          b.d = in_data[int'(sel)*W +: W];
          b.s = sel;
          q.push_back(b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_abc();
    in_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = '0; set_abc();
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0)
      $display("FAIL reset_out: got v=%b d=%h s=%0d want v=0 d=0 s=0", out_valid, out_data, out_sel);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    else n_pass++;
    n_checks++;
    if (bad_sel !== 1'b0 || bad_cnt !== 8'd0)
      $display("FAIL reset_bad: got bad_sel=%b bad_cnt=%0d want 0/0", bad_sel, bad_cnt);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    set_abc(); sel = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h2222_2222 || out_sel !== 2'd1)
      $display("FAIL basic_beat: got v=%b d=%h s=%0d want v=1 d=22222222 s=1", out_valid, out_data, out_sel);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL basic_drain: got out_valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    set_abc(); out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    tick();
    sel = 2'd1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_ready_second: got %b want 1", in_ready);
    else n_pass++;
    tick();
    sel = 2'd2;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_ready_third: got %b want 0", in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1111_1111 || out_sel !== 2'd0)
      $display("FAIL bp_stall_hold: got v=%b d=%h s=%0d want v=1 d=11111111 s=0", out_valid, out_data, out_sel);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_data !== 32'h2222_2222 || out_sel !== 2'd1 || in_ready !== 1'b1)
      $display("FAIL bp_skid_drain: got d=%h s=%0d rdy=%b want d=22222222 s=1 rdy=1", out_data, out_sel, in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h3333_3333 || out_sel !== 2'd2)
      $display("FAIL bp_reaccept: got v=%b d=%h s=%0d want v=1 d=33333333 s=2", out_valid, out_data, out_sel);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty: got out_valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_bad_select();
    set_abc(); out_ready = 1'b1; sel = 2'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || bad_sel !== 1'b1 || bad_cnt !== 8'd1)
      $display("FAIL bad_mode0: got v=%b bad_sel=%b cnt=%0d want v=0 bad_sel=1 cnt=1", out_valid, bad_sel, bad_cnt);
    else n_pass++;
    n_checks++;
    if (out_valid1 !== 1'b1 || out_data1 !== '0 || out_sel1 !== 2'd3 || bad_cnt1 !== 8'd1)
      $display("FAIL bad_mode1: got v=%b d=%h s=%0d cnt=%0d want v=1 d=0 s=3 cnt=1", out_valid1, out_data1, out_sel1, bad_cnt1);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid1 !== 1'b0) $display("FAIL bad_mode1_single: got out_valid=%b want 0", out_valid1);
    else n_pass++;
  endtask

  task automatic test_saturate();
    out_ready = 1'b1; sel = 2'd3;
    in_valid = 1'b1; tick();
    in_valid = 1'b0;
    n_checks++;
    if (bad_cnt2 !== 2'd2) $display("FAIL sat_count2: got %0d want 2", bad_cnt2);
    else n_pass++;
    in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    n_checks++;
    if (bad_cnt2 !== 2'd3 || bad_sel2 !== 1'b1)
      $display("FAIL sat_hold: got cnt=%0d bad_sel=%b want 3/1", bad_cnt2, bad_sel2);
    else n_pass++;
    n_checks++;
    if (bad_cnt !== 8'd5) $display("FAIL sat_wide_count: got %0d want 5", bad_cnt);
    else n_pass++;
  endtask

  task automatic test_stream();
    int sent = 0;
    int cyc  = 0;
    int errs = 0;
    while (sent < 100 && cyc < 3000) begin
      in_valid  = ($urandom % 4) != 0;
      sel       = SW'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom, $urandom};
      out_ready = ($urandom % 3) != 0;
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
      n_checks++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
        if (errs < 10) $display("FAIL stream_ctrl cyc %0d: got v=%b rdy=%b want v=%b rdy=%b",
                                cyc, out_valid, in_ready, q.size() != 0, q.size() < 2);
        errs++;
      end else n_pass++;
      if (q.size() != 0) begin
        n_checks++;
        if (out_data !== q[0].d || out_sel !== q[0].s) begin
          if (errs < 10) $display("FAIL stream_data cyc %0d: got d=%h s=%0d want d=%h s=%0d",
                                  cyc, out_data, out_sel, q[0].d, q[0].s);
          errs++;
        end else n_pass++;
      end
      n_checks++;
      if (bad_cnt !== 8'(m_cnt) || bad_sel !== m_bad) begin
        if (errs < 10) $display("FAIL stream_bad cyc %0d: got cnt=%0d flag=%b want cnt=%0d flag=%b",
                                cyc, bad_cnt, bad_sel, m_cnt, m_bad);
        errs++;
      end else n_pass++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (sent < 100) $display("FAIL stream_timeout: sent %0d beats want 100", sent);
    else n_pass++;
    out_ready = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || q.size() != 0)
      $display("FAIL stream_flush: got v=%b model_depth=%0d want 0/0", out_valid, q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    set_abc(); out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    tick();
    sel = 2'd1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL rmid_full: got rdy=%b v=%b want 0/1", in_ready, out_valid);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || bad_cnt !== 8'd0 || bad_sel !== 1'b0)
      $display("FAIL rmid_cleared: got v=%b cnt=%0d flag=%b want 0/0/0", out_valid, bad_cnt, bad_sel);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", in_ready);
    else n_pass++;
    out_ready = 1'b1; sel = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h3333_3333 || out_sel !== 2'd2)
      $display("FAIL rmid_fresh: got v=%b d=%h s=%0d want v=1 d=33333333 s=2", out_valid, out_data, out_sel);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rmid_no_stale: got out_valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = '0; in_data = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_bad_select();
    test_saturate();
    test_stream();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
